// File: rtl/fifo_wr_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_wr_ctrl
//   Write-side pointer and flag controller for an asynchronous FIFO. All logic
//   runs in the write clock domain. It keeps the binary and Gray write pointers,
//   synchronises the read-domain Gray pointer, and produces the full flag,
//   occupancy and a sticky overflow flag.
//
// Optional feature macro: FIFO_AFULL_EN (adds the registered almost_full_o)
//
// Ports
//   wr_clk         in   write-domain clock, rising edge
//   wr_rst_n       in   synchronous active-low reset
//   wr_en_i        in   producer write request
//   rd_ptr_gray_i  in   read pointer (Gray), asynchronous to wr_clk
//   wr_addr        out  memory write address (low bits of binary pointer)
//   full           out  registered full flag
//   wr_ptr_gray_o  out  registered Gray write pointer, to the read domain
//   wr_count_o     out  registered conservative occupancy, 0..DEPTH
//   overflow_o     out  sticky: write requested while full
//   almost_full_o  out  occupancy >= AFULL_THRESH (FIFO_AFULL_EN only)
// -----------------------------------------------------------------------------
module fifo_wr_ctrl #(
  parameter int DEPTH        = 8,
  parameter int ADDR_W       = 3,
  parameter int AFULL_THRESH = 6
) (
  input  logic              wr_clk,
  input  logic              wr_rst_n,
  input  logic              wr_en_i,
  input  logic [ADDR_W:0]   rd_ptr_gray_i,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              full,
  output logic [ADDR_W:0]   wr_ptr_gray_o,
  output logic [ADDR_W:0]   wr_count_o,
`ifdef FIFO_AFULL_EN
  output logic              almost_full_o,
`endif
  output logic              overflow_o
);

  // Elaboration-time sanity checks on the configuration.
  if (ADDR_W < 2 || DEPTH != (1 << ADDR_W)) begin : g_bad_depth
    $error("fifo_wr_ctrl: DEPTH must be 2**ADDR_W and at least 4");
  end
  if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH) begin : g_bad_thresh
    $error("fifo_wr_ctrl: AFULL_THRESH must lie in 1..DEPTH");
  end

  logic [ADDR_W:0] r_wbin;
  logic [ADDR_W:0] r_wgray;
  logic [ADDR_W:0] r_rq1;
  logic [ADDR_W:0] r_rq2;
  logic            r_full;
  logic [ADDR_W:0] r_count;
  logic            r_overflow;

  logic            w_accept;
  logic [ADDR_W:0] w_wbin_next;
  logic [ADDR_W:0] w_wgray_next;
  logic [ADDR_W:0] w_rbin_s;
  logic [ADDR_W:0] w_count_next;
  logic            w_full_next;

  // Same gating as the memory, so pointer and stored data never diverge.
  assign w_accept     = wr_en_i & ~r_full;
  assign w_wbin_next  = r_wbin + {{ADDR_W{1'b0}}, w_accept};
  assign w_wgray_next = w_wbin_next ^ (w_wbin_next >> 1);

  // Gray-to-binary of the synchronised read pointer: bit i is the XOR of all
  // bits at and above i.
  // NOTE: every variable written in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    w_rbin_s = '0;
    for (int i = 0; i <= ADDR_W; i++) begin
      w_rbin_s[i] = ^(r_rq2 >> i);
    end
  end

  // Full when the write pointer is exactly one lap ahead: top two Gray bits
  // inverted, the rest equal.
  assign w_full_next  = (w_wgray_next ==
                         {~r_rq2[ADDR_W:ADDR_W-1], r_rq2[ADDR_W-2:0]});
  // Uses the stale synchronised read pointer, so occupancy is never understated.
  assign w_count_next = w_wbin_next - w_rbin_s;

`ifdef FIFO_AFULL_EN
  localparam logic [ADDR_W:0] AFULL_T = AFULL_THRESH[ADDR_W:0];
  logic r_afull;
`endif

  // NOTE: reset is sampled on the clock edge only; there is deliberately no
  // asynchronous clear, so wr_rst_n is absent from the sensitivity list.
  // NOTE: state uses non-blocking assignments so every flop samples the
  // pre-edge values, which the two-stage synchroniser depends on.
  always_ff @(posedge wr_clk) begin
    if (!wr_rst_n) begin
      r_wbin     <= '0;
      r_wgray    <= '0;
      r_rq1      <= '0;
      r_rq2      <= '0;
      r_full     <= 1'b0;
      r_count    <= '0;
      r_overflow <= 1'b0;
`ifdef FIFO_AFULL_EN
      r_afull    <= 1'b0;
`endif
    end else begin
      r_wbin  <= w_wbin_next;
      r_wgray <= w_wgray_next;
      r_rq1   <= rd_ptr_gray_i;
      r_rq2   <= r_rq1;
      r_full  <= w_full_next;
      r_count <= w_count_next;
      if (wr_en_i && r_full) begin
        r_overflow <= 1'b1;
      end
`ifdef FIFO_AFULL_EN
      r_afull <= (w_count_next >= AFULL_T);
`endif
    end
  end

  assign wr_addr       = r_wbin[ADDR_W-1:0];
  assign full          = r_full;
  assign wr_ptr_gray_o = r_wgray;
  assign wr_count_o    = r_count;
  assign overflow_o    = r_overflow;
`ifdef FIFO_AFULL_EN
  assign almost_full_o = r_afull;
`endif

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fifo_wr_ctrl
//   Self-checking bench for fifo_wr_ctrl (DEPTH=8). Directed scenarios follow
//   the fill / overflow / release / wrap / mid-fill reset sequences, followed
//   by a randomized run against a pointer-arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_fifo_wr_ctrl;

  logic       wr_clk = 1'b0;
  logic       wr_rst_n;
  logic       wr_en_i;
  logic [3:0] rd_ptr_gray_i;
  logic [2:0] wr_addr;
  logic       full;
  logic [3:0] wr_ptr_gray_o;
  logic [3:0] wr_count_o;
  logic       overflow_o;
`ifdef FIFO_AFULL_EN
  logic       almost_full_o;
`endif

  int n_vec = 0;
  int n_err = 0;

  // Reference model: write count modulo 16, read pointer as seen after the
  // two-edge synchronisation delay, occupancy derived by subtraction.
  int m_wp, m_cnt, m_d1, m_d2;
  bit m_full, m_ovf, m_afull;

  fifo_wr_ctrl #(.DEPTH(8), .ADDR_W(3), .AFULL_THRESH(6)) dut (
    .wr_clk        (wr_clk),
    .wr_rst_n      (wr_rst_n),
    .wr_en_i       (wr_en_i),
    .rd_ptr_gray_i (rd_ptr_gray_i),
    .wr_addr       (wr_addr),
    .full          (full),
    .wr_ptr_gray_o (wr_ptr_gray_o),
    .wr_count_o    (wr_count_o),
`ifdef FIFO_AFULL_EN
    .almost_full_o (almost_full_o),
`endif
    .overflow_o    (overflow_o)
  );

  always #5 wr_clk = ~wr_clk;

  function automatic logic [3:0] to_gray(input int b);
    logic [3:0] v;
    v = 4'(b);
    return v ^ (v >> 1);
  endfunction

  // Apply one cycle of inputs, advance the model, then clock and settle.
  task automatic step(input bit en, input bit rst_n, input int rd_b);
    bit acc;
    wr_en_i       = en;
    wr_rst_n      = rst_n;
    rd_ptr_gray_i = to_gray(rd_b);
    if (!rst_n) begin
      m_wp = 0; m_cnt = 0; m_full = 0; m_ovf = 0; m_afull = 0;
      m_d1 = 0; m_d2 = 0;
    end else begin
      acc = en && !m_full;
      if (en && m_full) m_ovf = 1;
      m_wp    = (m_wp + int'(acc)) % 16;
      m_cnt   = (m_wp - m_d2 + 16) % 16;
      m_full  = (m_cnt == 8);
      m_afull = (m_cnt >= 6);
      m_d2    = m_d1;
      m_d1    = rd_b % 16;
    end
    @(posedge wr_clk);
    #1;
  endtask

  task automatic test_reset();
    step(1'b1, 1'b0, 5'b00110); // binary 6 -> Gray 4'b0101
    step(1'b1, 1'b0, 6);
    n_vec++;
    if (rd_ptr_gray_i !== 4'b0101) begin
      n_err++; $display("FAIL reset_stim gray=%b want 0101", rd_ptr_gray_i);
    end
    n_vec++;
    if (wr_addr !== 3'd0) begin n_err++; $display("FAIL reset_addr got %0d want 0", wr_addr); end
    n_vec++;
    if (wr_ptr_gray_o !== 4'd0) begin n_err++; $display("FAIL reset_gray got %b want 0000", wr_ptr_gray_o); end
    n_vec++;
    if (full !== 1'b0) begin n_err++; $display("FAIL reset_full got %b want 0", full); end
    n_vec++;
    if (wr_count_o !== 4'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", wr_count_o); end
    n_vec++;
    if (overflow_o !== 1'b0) begin n_err++; $display("FAIL reset_ovf got %b want 0", overflow_o); end
  endtask

  task automatic test_fill();
    for (int k = 1; k <= 8; k++) begin
      step(1'b1, 1'b1, 0);
      n_vec++;
      if (wr_addr !== 3'(k % 8)) begin
        n_err++; $display("FAIL fill_addr[%0d] got %0d want %0d", k, wr_addr, k % 8);
      end
      n_vec++;
      if (wr_count_o !== 4'(k)) begin
        n_err++; $display("FAIL fill_count[%0d] got %0d want %0d", k, wr_count_o, k);
      end
      n_vec++;
      if (full !== (k == 8)) begin
        n_err++; $display("FAIL fill_full[%0d] got %b want %b", k, full, k == 8);
      end
`ifdef FIFO_AFULL_EN
      n_vec++;
      if (almost_full_o !== (k >= 6)) begin
        n_err++; $display("FAIL fill_afull[%0d] got %b want %b", k, almost_full_o, k >= 6);
      end
`endif
    end
    n_vec++;
    if (wr_ptr_gray_o !== 4'b1100) begin
      n_err++; $display("FAIL fill_gray got %b want 1100", wr_ptr_gray_o);
    end
  endtask

  task automatic test_overflow();
    step(1'b1, 1'b1, 0);
    n_vec++;
    if (wr_addr !== 3'd0) begin n_err++; $display("FAIL ovf_addr got %0d want 0", wr_addr); end
    n_vec++;
    if (wr_ptr_gray_o !== 4'b1100) begin n_err++; $display("FAIL ovf_gray got %b want 1100", wr_ptr_gray_o); end
    n_vec++;
    if (overflow_o !== 1'b1) begin n_err++; $display("FAIL ovf_set got %b want 1", overflow_o); end
    step(1'b0, 1'b1, 0);
    n_vec++;
    if (overflow_o !== 1'b1) begin n_err++; $display("FAIL ovf_sticky got %b want 1", overflow_o); end
    n_vec++;
    if (full !== 1'b1) begin n_err++; $display("FAIL ovf_full got %b want 1", full); end
  endtask

  task automatic test_release();
    for (int e = 1; e <= 3; e++) begin
      step(1'b0, 1'b1, 1); // Gray 4'b0001
      n_vec++;
      if (full !== (e < 3)) begin
        n_err++; $display("FAIL release_full[%0d] got %b want %b", e, full, e < 3);
      end
      n_vec++;
      if (wr_count_o !== ((e < 3) ? 4'd8 : 4'd7)) begin
        n_err++; $display("FAIL release_count[%0d] got %0d want %0d", e, wr_count_o, (e < 3) ? 8 : 7);
      end
      n_vec++;
      if (overflow_o !== 1'b1) begin
        n_err++; $display("FAIL release_ovf[%0d] got %b want 1", e, overflow_o);
      end
    end
  endtask

  task automatic test_wrap();
    logic [3:0] prev;
    step(1'b0, 1'b0, 0);
    prev = wr_ptr_gray_o;
    for (int k = 0; k < 16; k++) begin
      step(1'b1, 1'b1, (k >= 2) ? k - 2 : 0);
      n_vec++;
      if ($countones(prev ^ wr_ptr_gray_o) != 1) begin
        n_err++; $display("FAIL wrap_onebit[%0d] %b -> %b", k, prev, wr_ptr_gray_o);
      end
      n_vec++;
      if (wr_ptr_gray_o !== to_gray(k + 1)) begin
        n_err++; $display("FAIL wrap_gray[%0d] got %b want %b", k, wr_ptr_gray_o, to_gray(k + 1));
      end
      n_vec++;
      if (full !== 1'b0 || wr_count_o > 4'd5) begin
        n_err++; $display("FAIL wrap_level[%0d] full=%b count=%0d want full=0 count<=5", k, full, wr_count_o);
      end
      if (k == 15) begin
        n_vec++;
        if (prev !== 4'b1000 || wr_ptr_gray_o !== 4'b0000) begin
          n_err++; $display("FAIL wrap_end got %b->%b want 1000->0000", prev, wr_ptr_gray_o);
        end
      end
      prev = wr_ptr_gray_o;
    end
  endtask

  task automatic test_reset_mid_fill();
    step(1'b0, 1'b0, 0);
    for (int k = 0; k < 5; k++) step(1'b1, 1'b1, 0);
    n_vec++;
    if (wr_addr !== 3'd5) begin n_err++; $display("FAIL midrst_pre got %0d want 5", wr_addr); end
    step(1'b1, 1'b0, 0);
    n_vec++;
    if (wr_addr !== 3'd0 || wr_ptr_gray_o !== 4'd0 || full !== 1'b0 ||
        wr_count_o !== 4'd0 || overflow_o !== 1'b0) begin
      n_err++;
      $display("FAIL midrst_zero addr=%0d gray=%b full=%b count=%0d ovf=%b want all 0",
               wr_addr, wr_ptr_gray_o, full, wr_count_o, overflow_o);
    end
    step(1'b1, 1'b1, 0);
    n_vec++;
    if (wr_addr !== 3'd1 || wr_count_o !== 4'd1) begin
      n_err++; $display("FAIL midrst_first addr=%0d count=%0d want 1 1", wr_addr, wr_count_o);
    end
  endtask

  task automatic test_random();
    int rd_b;
    bit en, rst_n;
    rd_b = 0;
    step(1'b0, 1'b0, 0);
    for (int n = 0; n < 600; n++) begin
      rst_n = ($urandom_range(99) != 0);
      en    = ($urandom_range(9) < 7);
      if (!rst_n) rd_b = 0;
      else if (((m_wp - rd_b + 16) % 16) != 0 && $urandom_range(1) == 1) rd_b = (rd_b + 1) % 16;
      step(en, rst_n, rd_b);
      n_vec++;
      if (wr_addr !== 3'(m_wp % 8)) begin
        n_err++; $display("FAIL rand_addr[%0d] got %0d want %0d", n, wr_addr, m_wp % 8);
      end
      n_vec++;
      if (wr_ptr_gray_o !== to_gray(m_wp)) begin
        n_err++; $display("FAIL rand_gray[%0d] got %b want %b", n, wr_ptr_gray_o, to_gray(m_wp));
      end
      n_vec++;
      if (wr_count_o !== 4'(m_cnt)) begin
        n_err++; $display("FAIL rand_count[%0d] got %0d want %0d", n, wr_count_o, m_cnt);
      end
      n_vec++;
      if (full !== m_full) begin
        n_err++; $display("FAIL rand_full[%0d] got %b want %b", n, full, m_full);
      end
      n_vec++;
      if (overflow_o !== m_ovf) begin
        n_err++; $display("FAIL rand_ovf[%0d] got %b want %b", n, overflow_o, m_ovf);
      end
`ifdef FIFO_AFULL_EN
      n_vec++;
      if (almost_full_o !== m_afull) begin
        n_err++; $display("FAIL rand_afull[%0d] got %b want %b", n, almost_full_o, m_afull);
      end
`endif
    end
  endtask

  initial begin
    wr_rst_n      = 1'b0;
    wr_en_i       = 1'b0;
    rd_ptr_gray_i = '0;
    m_wp = 0; m_cnt = 0; m_d1 = 0; m_d2 = 0;
    m_full = 0; m_ovf = 0; m_afull = 0;
    #2;
    test_reset();
    test_fill();
    test_overflow();
    test_release();
    test_wrap();
    test_reset_mid_fill();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
